// File: rtl/adc_scan_sequencer_pkg.sv
// Shared FSM encoding and SPI command layout for the ADC scan sequencer.
package adc_scan_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_PUSH      = 3'd4
    } state_t;

    // Bit positions are counted down from the command word MSB.
    localparam int CMD_CONVERT_MSB_OFS = 0;
    localparam int CMD_CH_MSB_OFS      = 1;

endpackage

// File: rtl/adc_scan_sequencer_sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO holding tagged ADC samples.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 19,
    parameter int AW    = 3,
    parameter int DEPTH = 1 << AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic scan of enabled ADC channels over the SPI master; tagged results go to a FWFT FIFO.
// Latency: tick->spi_start 2 cycles, spi_new_data->FIFO write 1 cycle. ADC_PIPELINED_RESULT_EN: result of frame n tagged with frame n-1.
// Backpressure: a full FIFO drops the sample (sticky overflow); a tick during a scan is dropped (sticky overrun).
module adc_scan_sequencer
    import adc_scan_sequencer_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int CH_WIDTH     = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_AW      = 3,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [NUM_CH-1:0]       ch_mask,
    output logic                    spi_start,
    output logic [DATA_WIDTH-1:0]   spi_data_in,
    input  logic                    spi_busy,
    input  logic                    spi_new_data,
    input  logic [DATA_WIDTH-1:0]   spi_data_out,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic [DATA_WIDTH-1:0]   sample_data,
    output logic [CH_WIDTH-1:0]     sample_ch,
    output logic                    scan_done,
    output logic                    overflow,
    output logic                    overrun,
    input  logic                    clear_flags
);
    state_t                           state, state_nxt;
    logic [PERIOD_WIDTH-1:0]          timer;
    logic                             tick;
    logic [CH_WIDTH:0]                idx;
    logic [CH_WIDTH-1:0]              cur_ch;
    logic [DATA_WIDTH-1:0]            cmd;
    logic [DATA_WIDTH-1:0]            result;
    logic                             found;
    logic [CH_WIDTH-1:0]              found_ch;
    logic                             more;
    logic                             push_en;
    logic                             fifo_push;
    logic                             fifo_pop;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic [CH_WIDTH+DATA_WIDTH-1:0]   push_word;
    logic [CH_WIDTH+DATA_WIDTH-1:0]   fifo_head;

    function automatic logic [DATA_WIDTH-1:0] cmd_word(input logic [CH_WIDTH-1:0] ch);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        w[DATA_WIDTH-1-CMD_CONVERT_MSB_OFS] = 1'b1;
        w[DATA_WIDTH-1-CMD_CH_MSB_OFS -: CH_WIDTH] = ch;
        return w;
    endfunction

    assign tick = enable && (timer == period);

    always_ff @(posedge clk) begin
        if (rst || !enable || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Lowest set mask bit at or above idx: the descending loop leaves the lowest hit.
    always_comb begin
        found    = 1'b0;
        found_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i] && ((CH_WIDTH+1)'(i) >= idx)) begin
                found    = 1'b1;
                found_ch = CH_WIDTH'(i);
            end
        end
    end

`ifdef ADC_PIPELINED_RESULT_EN
    logic [CH_WIDTH-1:0] prev_ch;
    logic                have_prev;
    logic                dummy_sent;

    // One trailing frame repeating the last command collects the final result.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ch    <= '0;
            have_prev  <= 1'b0;
            dummy_sent <= 1'b0;
        end else begin
            if (state == ST_IDLE && tick) begin
                have_prev  <= 1'b0;
                dummy_sent <= 1'b0;
            end
            if (state == ST_SELECT && !found && have_prev && !dummy_sent) begin
                dummy_sent <= 1'b1;
            end
            if (state == ST_PUSH) begin
                prev_ch   <= cur_ch;
                have_prev <= 1'b1;
            end
        end
    end

    assign more      = found || (have_prev && !dummy_sent);
    assign push_en   = have_prev;
    assign push_word = {prev_ch, result};
`else
    assign more      = found;
    assign push_en   = 1'b1;
    assign push_word = {cur_ch, result};
`endif

    always_comb begin
        state_nxt = state;
        spi_start = 1'b0;
        scan_done = 1'b0;
        fifo_push = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                if (more) begin
                    state_nxt = ST_START;
                end else begin
                    scan_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (!spi_busy) begin
                    spi_start = 1'b1;
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (spi_new_data) state_nxt = ST_PUSH;
            end
            ST_PUSH: begin
                fifo_push = push_en;
                state_nxt = ST_SELECT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cur_ch   <= '0;
            cmd      <= '0;
            result   <= '0;
            overflow <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && tick) idx <= '0;
            if (state == ST_SELECT && found) begin
                cur_ch <= found_ch;
                cmd    <= cmd_word(found_ch);
            end
            if (state == ST_WAIT_DONE && spi_new_data) result <= spi_data_out;
            if (state == ST_PUSH) idx <= {1'b0, cur_ch} + 1'b1;
            if (fifo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (tick && state != ST_IDLE) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
        end
    end

    assign spi_data_in  = cmd;
    assign fifo_pop     = sample_valid && sample_ready;
    assign sample_valid = !fifo_empty;
    assign {sample_ch, sample_data} = fifo_head;

    sample_fifo #(
        .WIDTH (CH_WIDTH + DATA_WIDTH),
        .AW    (FIFO_AW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_word),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: random SPI slave latencies, random consumer, scan-plan reference model.
module tb_adc_scan_sequencer;
    localparam int NUM_CH       = 8;
    localparam int CH_WIDTH     = 3;
    localparam int DATA_WIDTH   = 16;
    localparam int FIFO_DEPTH   = 8;
    localparam int FIFO_AW      = 3;
    localparam int PERIOD_WIDTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] period;
    logic [7:0]  ch_mask;
    logic        spi_start;
    logic [15:0] spi_data_in;
    logic        spi_busy;
    logic        spi_new_data;
    logic [15:0] spi_data_out;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] sample_data;
    logic [2:0]  sample_ch;
    logic        scan_done;
    logic        overflow;
    logic        overrun;
    logic        clear_flags;

    adc_scan_sequencer #(
        .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW), .PERIOD_WIDTH(PERIOD_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .ch_mask(ch_mask),
        .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_busy(spi_busy),
        .spi_new_data(spi_new_data), .spi_data_out(spi_data_out),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_data(sample_data), .sample_ch(sample_ch), .scan_done(scan_done),
        .overflow(overflow), .overrun(overrun), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference plan: channel and result tag of every frame, frames per scan, expected samples.
    int          frame_ch[$];
    int          frame_tag[$];
    int          frame_scan[$];
    int          scan_nfr[$];
    logic [18:0] exp_q[$];
    logic [15:0] word_q[$];
    int          cyc = 0;
    int          fidx, cur_frame, scan_cnt, c0, per_i, last_nd, last_busy, force_lat_frame;
    int          slv_due, slv_trail;
    bit          slv_active, tchk, hold, rst_chk;
    logic [15:0] slv_word, held_cmd;

    function automatic logic [15:0] cmd_of(input int ch);
        return 16'h8000 | 16'(ch << 12);
    endfunction

    task automatic plan(input logic [7:0] mask, input int nscans);
        frame_ch.delete(); frame_tag.delete(); frame_scan.delete(); scan_nfr.delete(); exp_q.delete();
        fidx = 0; cur_frame = -1; scan_cnt = 0; last_nd = -100; last_busy = -100;
        for (int s = 0; s < nscans; s++) begin
            int chs[$];
            for (int i = 0; i < NUM_CH; i++) if (mask[i]) chs.push_back(i);
`ifdef ADC_PIPELINED_RESULT_EN
            if (chs.size() > 0) chs.push_back(chs[chs.size()-1]);
            foreach (chs[j]) begin
                frame_ch.push_back(chs[j]);
                frame_tag.push_back(j == 0 ? -1 : chs[j-1]);
                frame_scan.push_back(s);
            end
`else
            foreach (chs[j]) begin
                frame_ch.push_back(chs[j]);
                frame_tag.push_back(chs[j]);
                frame_scan.push_back(s);
            end
`endif
            scan_nfr.push_back(chs.size());
        end
    endtask

    // One clock: sample and check at negedge, drive slave/consumer just after posedge.
    task automatic step();
        int exp_t, lat, trail;
        @(negedge clk);
        if (rst) begin
            slv_active = 0; slv_due = -1; slv_trail = -1;
        end else begin
            if (rst_chk) begin
                check("rst_spi_start", 32'(spi_start), 0);
                check("rst_spi_data_in", 32'(spi_data_in), 0);
                check("rst_sample_valid", 32'(sample_valid), 0);
                check("rst_scan_done", 32'(scan_done), 0);
                check("rst_overflow", 32'(overflow), 0);
                check("rst_overrun", 32'(overrun), 0);
                rst_chk = 0;
            end
            if (spi_busy) last_busy = cyc;
            if (spi_start) begin
                check("start_in_frame", 32'(slv_active), 0);
                check("frame_in_plan", 32'(fidx < frame_ch.size()), 1);
                if (fidx < frame_ch.size()) begin
                    check("cmd", 32'(spi_data_in), 32'(cmd_of(frame_ch[fidx])));
                    if (tchk) begin
                        if (fidx == 0 || frame_scan[fidx] != frame_scan[fidx-1])
                            exp_t = c0 + per_i + 2 + frame_scan[fidx] * (per_i + 1);
                        else
                            exp_t = last_nd + 3;
                        if (last_busy + 1 > exp_t) exp_t = last_busy + 1;
                        check("start_cycle", cyc, exp_t);
                    end
                end
                lat   = (fidx == force_lat_frame) ? 30 : int'($urandom_range(0, 3));
                trail = int'($urandom_range(0, 5));
                slv_active = 1;
                slv_due    = cyc + 1 + lat;
                slv_trail  = slv_due + trail;
                slv_word   = (word_q.size() > 0) ? word_q.pop_front() : 16'($urandom);
                held_cmd   = spi_data_in;
                cur_frame  = fidx;
                fidx++;
            end
            if (spi_new_data) begin
                check("cmd_hold", 32'(spi_data_in), 32'(held_cmd));
                last_nd = cyc;
                slv_active = 0;
                if (cur_frame >= 0 && cur_frame < frame_tag.size() && frame_tag[cur_frame] >= 0)
                    if (!hold || exp_q.size() < FIFO_DEPTH)
                        exp_q.push_back({3'(frame_tag[cur_frame]), slv_word});
            end
            if (scan_done) begin
                if (tchk && scan_cnt < scan_nfr.size()) begin
                    exp_t = (scan_nfr[scan_cnt] == 0) ? c0 + per_i + 1 + scan_cnt * (per_i + 1)
                                                      : last_nd + 2;
                    check("done_cycle", cyc, exp_t);
                end
                scan_cnt++;
            end
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) check("sample_extra", exp_q.size(), 1);
                else check("sample", 32'({sample_ch, sample_data}), 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        spi_new_data = slv_active && (cyc == slv_due);
        spi_busy     = (slv_active && cyc < slv_due) || (cyc > slv_due && cyc <= slv_trail);
        spi_data_out = spi_new_data ? slv_word : 16'h0;
        sample_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic start_phase(input logic [7:0] mask, input int per, input int nscans, input bit tc);
        ch_mask = mask;
        period  = 16'(per);
        per_i   = per;
        plan(mask, nscans);
        tchk    = tc;
        c0      = cyc;
        enable  = 1'b1;
    endtask

    task automatic run_scans(input int nscans);
        int n = 0;
        int budget = (per_i + 1) * (nscans + 1) + 300;
        while (scan_cnt < nscans && n < budget) begin
            step();
            n++;
        end
        check("scans_done", scan_cnt, nscans);
        enable = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || slv_active) && n < 400) begin
            step();
            n++;
        end
        repeat (4) step();
        check("drained", exp_q.size(), 0);
        check("frame_count", fidx, frame_ch.size());
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; period = '0; ch_mask = '0; clear_flags = 1'b0;
        spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = '0; sample_ready = 1'b0;
        tchk = 0; hold = 0; rst_chk = 0; force_lat_frame = -1;
        slv_active = 0; slv_due = -1; slv_trail = -1;
        plan(8'h00, 0);
        repeat (3) step();
        rst = 1'b0;
        rst_chk = 1;
        step();

        // Directed two-channel scan with known words and long interval.
        word_q = '{16'h1234, 16'hABCD};
        start_phase(8'h05, 999, 2, 1);
        run_scans(2);
        drain();
        check("ovf_after_05", 32'(overflow), 0);
        check("ovr_after_05", 32'(overrun), 0);

        // Empty mask: scan_done every period+1 cycles, no frames.
        start_phase(8'h00, 20, 3, 1);
        run_scans(3);
        drain();

        for (int r = 0; r < 4; r++) begin
            start_phase(8'($urandom), 120 + int'($urandom_range(0, 60)), 2, 1);
            run_scans(2);
            drain();
            check("ovf_random", 32'(overflow), 0);
            check("ovr_random", 32'(overrun), 0);
        end

        // Consumer stalled over two full scans: FIFO keeps the first 8 samples.
        hold = 1;
        sample_ready = 1'b0;
        start_phase(8'hFF, 149, 2, 1);
        run_scans(2);
        repeat (4) step();
        check("hold_overflow", 32'(overflow), 1);
        check("hold_valid", 32'(sample_valid), 1);
        check("hold_head", 32'({sample_ch, sample_data}), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hFFFF_FFFF);
        check("hold_entries", exp_q.size(), FIFO_DEPTH);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check("clear_overflow", 32'(overflow), 0);
        hold = 0;
        drain();

        // Interval shorter than a scan: ticks dropped, overrun sticky, scans still complete.
        start_phase(8'hFF, 10, 2, 0);
        run_scans(2);
        check("overrun_set", 32'(overrun), 1);
        drain();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check("clear_overrun", 32'(overrun), 0);

        // Reset while waiting on the ch3 frame, then restart from ch0.
        force_lat_frame = 3;
        start_phase(8'hFF, 149, 1, 0);
        begin
            int n = 0;
            while (fidx < 4 && n < 600) begin
                step();
                n++;
            end
        end
        check("reached_ch3", fidx, 4);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        force_lat_frame = -1;
        plan(8'hFF, 1);
        c0 = cyc;
        tchk = 1;
        rst_chk = 1;
        run_scans(1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
